gcd_requester: RTL and testbench

//  Initiator side of the GCD start/done interface. Accepts operand pairs on a

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_requester.sv | 104 ++++++++++
 tb/tb_gcd_requester.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: default widths, watchdog limit
// and the requester FSM state encoding.
package gcd_pkg;

    localparam int GCD_W       = 16;
    localparam int GCD_TIMEOUT = 65535;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        DRAIN     = 3'd3,
        RESULT    = 3'd4
    } state_t;

endpackage

// File: rtl/gcd_requester.sv
// Initiator side of the GCD start/done interface: issues one operand pair to the
// core, captures the result (or a watchdog timeout) and hands it downstream.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         core_start,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_b,
    input  logic         core_done,
    input  logic [W-1:0] core_gcd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic         out_timeout,
    output logic         busy
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    state_t          state;
    logic [WD_W-1:0] watchdog;

    // NOTE: in_ready/busy are plain decodes of the registered state, so no latch
    // and no extra cycle of delay; every other output is a register below.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            watchdog    <= '0;
            core_start  <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            out_valid   <= 1'b0;
            out_gcd     <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        core_a     <= in_a;
                        core_b     <= in_b;
                        out_a      <= in_a;
                        out_b      <= in_b;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start <= 1'b0;
                    watchdog   <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (watchdog != WD_MAX) begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                    // A real result wins over a timeout landing on the same cycle.
                    if (core_done) begin
                        out_gcd     <= core_gcd;
                        out_timeout <= 1'b0;
                        state       <= DRAIN;
                    end else if (watchdog == WD_LAST) begin
                        out_gcd     <= '0;
                        out_timeout <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Hold off until the core's done window closes so the next
                    // start is not issued while the core would ignore it.
                    if (!core_done) begin
                        out_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: a behavioural GCD core, a queue-based result model
// checked every cycle, and directed scenarios with literal expectations.
module tb_gcd_requester;

    logic        clk;
    logic        rst;
    logic        core_rst;

    logic        in_valid, in_ready, core_start, core_done, out_valid, out_ready, out_timeout, busy;
    logic [15:0] in_a, in_b, core_a, core_b, core_gcd, out_gcd, out_a, out_b;

    logic        t_in_valid, t_in_ready, t_core_start, t_out_valid, t_out_ready, t_out_timeout, t_busy;
    logic [15:0] t_in_a, t_in_b, t_core_a, t_core_b, t_out_gcd, t_out_a, t_out_b;

    int tests = 0;
    int fails = 0;

    gcd_requester dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_done(core_done),
        .core_gcd(core_gcd), .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
        .out_a(out_a), .out_b(out_b), .out_timeout(out_timeout), .busy(busy)
    );

    // Second instance with a short watchdog and a core that never finishes.
    gcd_requester #(.W(16), .TIMEOUT(8)) dut_to (
        .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(t_in_a),
        .in_b(t_in_b), .core_start(t_core_start), .core_a(t_core_a), .core_b(t_core_b),
        .core_done(1'b0), .core_gcd(16'h0000), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .out_gcd(t_out_gcd), .out_a(t_out_a), .out_b(t_out_b), .out_timeout(t_out_timeout),
        .busy(t_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench hung");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int euclid_steps(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        int n;
        x = a;
        y = b;
        n = 0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
            n++;
        end
        return n;
    endfunction

    // Behavioural core: latency grows with Euclid steps, done held two cycles.
    int spur_cnt = 0;
    initial begin : core_model
        logic [15:0] g;
        int lat, spur_seen;
        bit aborted;
        spur_seen = 0;
        core_done = 1'b0;
        core_gcd  = 16'h0000;
        forever begin
            @(posedge clk);
            if (core_rst) continue;
            if (spur_cnt != spur_seen) begin
                spur_seen++;
                #1 core_done = 1'b1;
                core_gcd = 16'h5555;
                @(posedge clk);
                @(posedge clk);
                #1 core_done = 1'b0;
            end else if (core_start) begin
                g       = ref_gcd(core_a, core_b);
                lat     = 2 + euclid_steps(core_a, core_b);
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk);
                    if (core_rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    #1 core_done = 1'b1;
                    core_gcd = g;
                    @(posedge clk);
                    @(posedge clk);
                    #1 core_done = 1'b0;
                    core_gcd = 16'hdead;
                end
            end
        end
    end

    // Result model: every accepted pair must come back, in order, as its gcd.
    typedef struct {
        logic [15:0] g;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    initial begin : compare
        exp_t q[$];
        int   marks[$];
        int   start_cnt;
        bit   pending;
        exp_t e;
        start_cnt = 0;
        pending   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                marks.delete();
                pending = 1'b0;
            end else begin
                check("in_ready_vs_model", 32'(in_ready), 32'(!pending));
                check("busy_vs_model", 32'(busy), 32'(pending));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        check("model_out_gcd", 32'(out_gcd), 32'(q[0].g));
                        check("model_out_a", 32'(out_a), 32'(q[0].a));
                        check("model_out_b", 32'(out_b), 32'(q[0].b));
                        check("model_out_timeout", 32'(out_timeout), 32'd0);
                    end
                end
                if (in_valid && in_ready) begin
                    e.g = ref_gcd(in_a, in_b);
                    e.a = in_a;
                    e.b = in_b;
                    q.push_back(e);
                    marks.push_back(start_cnt);
                    pending = 1'b1;
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    check("core_start_pulses", 32'(start_cnt - marks[0]), 32'd1);
                    void'(q.pop_front());
                    void'(marks.pop_front());
                    pending = 1'b0;
                end
                if (core_start) start_cnt++;
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 1000) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eg);
        int cyc;
        send(a, b);
        wait_valid(cyc);
        check("lit_out_gcd", 32'(out_gcd), 32'(eg));
        check("lit_out_a", 32'(out_a), 32'(a));
        check("lit_out_b", 32'(out_b), 32'(b));
        check("lit_out_timeout", 32'(out_timeout), 32'd0);
        @(posedge clk);
        #1 check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin : stimulus
        int cyc;
        rst         = 1'b1;
        core_rst    = 1'b1;
        in_valid    = 1'b0;
        in_a        = 16'h0000;
        in_b        = 16'h0000;
        out_ready   = 1'b1;
        t_in_valid  = 1'b0;
        t_in_a      = 16'h0000;
        t_in_b      = 16'h0000;
        t_out_ready = 1'b0;

        #3;
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_a", 32'(core_a), 32'd0);
        check("rst_core_b", 32'(core_b), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_timeout", 32'(out_timeout), 32'd0);
        check("rst_out_gcd", 32'(out_gcd), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        core_rst = 1'b0;

        // (48,18): start at edge 1, core latency 5, done sampled at edges 7-8,
        // out_valid after edge 9.
        send(16'd48, 16'd18);
        wait_valid(cyc);
        check("t1_latency", 32'(cyc), 32'd9);
        check("t1_out_gcd", 32'(out_gcd), 32'd6);
        check("t1_out_a", 32'(out_a), 32'd48);
        check("t1_out_b", 32'(out_b), 32'd18);
        check("t1_out_timeout", 32'(out_timeout), 32'd0);
        @(posedge clk);
        #1 check("t1_in_ready_after", 32'(in_ready), 32'd1);

        run_one(16'd0, 16'd35, 16'd35);
        run_one(16'd35, 16'd0, 16'd35);
        run_one(16'd0, 16'd0, 16'd0);
        run_one(16'd65535, 16'd1, 16'd1);

        // Back-pressure; the second pair waits behind the held result.
        out_ready = 1'b0;
        send(16'd12, 16'd8);
        wait_valid(cyc);
        check("t4_out_gcd", 32'(out_gcd), 32'd4);
        fork
            send(16'd17, 16'd5);
            begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check("t4_hold_valid", 32'(out_valid), 32'd1);
                    check("t4_hold_gcd", 32'(out_gcd), 32'd4);
                    check("t4_hold_in_ready", 32'(in_ready), 32'd0);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
            end
        join
        wait_valid(cyc);
        check("t4_second_gcd", 32'(out_gcd), 32'd1);
        check("t4_second_a", 32'(out_a), 32'd17);
        check("t4_second_b", 32'(out_b), 32'd5);
        @(posedge clk);
        #1;

        // A done window while idle must not produce a result.
        spur_cnt++;
        repeat (6) @(posedge clk);
        #1;
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_out_valid", 32'(out_valid), 32'd0);

        // Reset while waiting on the core.
        send(16'd100, 16'd75);
        @(posedge clk);
        #1 check("t6_busy_before", 32'(busy), 32'd1);
        rst      = 1'b1;
        core_rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_core_start", 32'(core_start), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        core_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 run_one(16'd100, 16'd75, 16'd25);

        // TIMEOUT=8 with a dead core: DRAIN at edge 9, out_valid after edge 10.
        t_in_valid = 1'b1;
        t_in_a     = 16'd7;
        t_in_b     = 16'd3;
        @(negedge clk);
        check("t5_in_ready", 32'(t_in_ready), 32'd1);
        @(posedge clk);
        #1 t_in_valid = 1'b0;
        cyc = 0;
        while (!t_out_valid && cyc < 50) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("t5_latency_in_range", 32'(cyc >= 9 && cyc <= 10), 32'd1);
        check("t5_out_valid", 32'(t_out_valid), 32'd1);
        check("t5_out_timeout", 32'(t_out_timeout), 32'd1);
        check("t5_out_gcd", 32'(t_out_gcd), 32'd0);
        check("t5_out_a", 32'(t_out_a), 32'd7);
        check("t5_out_b", 32'(t_out_b), 32'd3);
        check("t5_core_a", 32'(t_core_a), 32'd7);
        check("t5_core_b", 32'(t_core_b), 32'd3);
        check("t5_core_start", 32'(t_core_start), 32'd0);
        t_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5_out_valid_after", 32'(t_out_valid), 32'd0);
        check("t5_busy_after", 32'(t_busy), 32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
